tpu_output_collector: RTL and testbench

- Downstream stage of the TPU top: captures the diagonally skewed result rows leaving the systolic array, deskews them, and stores a full result matrix in a local row buffer.
- Exposes that buffer and a status word to the host over the Avalon-MM slave read path, in address region 2'b11, alongside the existing control (00), weight (01) and input (10) regions.
- Signals completion with a status bit and a one-cycle interrupt pulse.

---
 rtl/tpu_pkg.sv | 32 +++
 rtl/tpu_deskew_line.sv | 52 +++++
 rtl/tpu_output_collector.sv | 182 ++++++++++++++++++
 tb/tb_tpu_output_collector.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tpu_pkg
// Description : Shared constants and types for the TPU host interface and
//               the output collector (address regions, status layout, FSM).
// Revision    : 1.0 - initial release
// ============================================================================
package tpu_pkg;

  // Avalon address regions, selected by slave_address[9:8]
  localparam logic [1:0] CONTROL_OFFSET = 2'b00;
  localparam logic [1:0] WEIGHT_OFFSET  = 2'b01;
  localparam logic [1:0] INPUT_OFFSET   = 2'b10;
  localparam logic [1:0] OUTPUT_OFFSET  = 2'b11;

  // Word offset of the collector status register inside the output region
  localparam logic [7:0] STATUS_ADDR = 8'h80;

  // Bit positions inside the status word
  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;
  localparam int STAT_ERR_BIT  = 2;

  // Collector state machine encoding
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } collector_state_e;

endpackage : tpu_pkg
`default_nettype wire

// File: rtl/tpu_deskew_line.sv
`default_nettype none
// ============================================================================
// Module      : tpu_deskew_line
// Description : Delays a {valid, data} pair by DEPTH cycles. DEPTH=0 is a
//               plain wire. flush_i drops everything in flight (including
//               the value entering on this edge).
// Revision    : 1.0 - initial release
// ============================================================================
module tpu_deskew_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  if (DEPTH == 0) begin : g_pass
    assign valid_o = valid_i;
    assign data_o  = data_i;
    // Clock, reset and flush have no role on a zero-delay column
    logic w_unused_ctrl;
    assign w_unused_ctrl = &{1'b0, clk, reset, flush_i};
  end else begin : g_shift
    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];

    // Shift valid and data one stage per cycle; flush kills every valid
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        valid_q <= '0;
        for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      end else begin
        valid_q[0] <= valid_i & ~flush_i;
        data_q[0]  <= data_i;
        for (int i = 1; i < DEPTH; i++) begin
          valid_q[i] <= valid_q[i-1] & ~flush_i;
          data_q[i]  <= data_q[i-1];
        end
      end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign data_o  = data_q[DEPTH-1];
  end

endmodule : tpu_deskew_line
`default_nettype wire

// File: rtl/tpu_output_collector.sv
`default_nettype none
// ============================================================================
// Module      : tpu_output_collector
// Description : Deskews result rows leaving the systolic array, stores one
//               full result matrix, and serves it plus a status word on the
//               Avalon-MM read path (region 2'b11). Pulses irq on completion.
// Revision    : 1.0 - initial release
// ============================================================================
module tpu_output_collector
  import tpu_pkg::*;
#(
  parameter int WIDTH_HEIGHT = 16,
  parameter int OUT_WIDTH    = 16,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [WIDTH_HEIGHT-1:0]           arr_valid,
  input  logic [WIDTH_HEIGHT*OUT_WIDTH-1:0] arr_data,
  input  logic [9:0]                        slave_address,
  input  logic                              slave_read,
  output logic [DATA_WIDTH-1:0]             slave_readdata,
  output logic                              busy,
  output logic                              done,
  output logic                              err,
  output logic                              irq
);

  localparam int ROW_BITS = WIDTH_HEIGHT * OUT_WIDTH;
  localparam int ROW_AW   = $clog2(WIDTH_HEIGHT);
  localparam int WORD_AW  = $clog2(WIDTH_HEIGHT / 2);
  localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(WIDTH_HEIGHT - 1);

  // --------------------------------------------------------------------------
  // Deskew: column c waits WIDTH_HEIGHT-1-c cycles so a row lines up
  // --------------------------------------------------------------------------
  logic [WIDTH_HEIGHT-1:0] w_dvalid;
  logic [ROW_BITS-1:0]     w_drow;

  for (genvar c = 0; c < WIDTH_HEIGHT; c++) begin : g_col
    tpu_deskew_line #(
      .DEPTH (WIDTH_HEIGHT - 1 - c),
      .WIDTH (OUT_WIDTH)
    ) u_line (
      .clk     (clk),
      .reset   (reset),
      .flush_i (start),
      .valid_i (arr_valid[c]),
      .data_i  (arr_data[c*OUT_WIDTH +: OUT_WIDTH]),
      .valid_o (w_dvalid[c]),
      .data_o  (w_drow[c*OUT_WIDTH +: OUT_WIDTH])
    );
  end

  logic w_aligned;
  logic w_mixed;
  assign w_aligned = &w_dvalid;
  assign w_mixed   = (|w_dvalid) & ~w_aligned;

  // --------------------------------------------------------------------------
  // Collector FSM
  // --------------------------------------------------------------------------
  collector_state_e  state_q, state_d;
  logic [ROW_AW-1:0] row_count_q, row_count_d;
  logic              err_q, err_d;
  logic              irq_q, irq_d;
  logic              w_wr_en;

  // Next-state decode; a start always wins over row activity in that cycle
  always_comb begin
    state_d     = state_q;
    row_count_d = row_count_q;
    err_d       = err_q;
    irq_d       = 1'b0;
    w_wr_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = COLLECT;
          row_count_d = '0;
          err_d       = 1'b0;
        end
      end
      COLLECT: begin
        if (start) begin
          row_count_d = '0;
          err_d       = 1'b0;
        end else if (w_aligned) begin
          w_wr_en     = 1'b1;
          row_count_d = row_count_q + 1'b1;
          if (row_count_q == LAST_ROW) begin
            state_d = DONE;
            irq_d   = 1'b1;
          end
        end else if (w_mixed) begin
          err_d = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          state_d     = COLLECT;
          row_count_d = '0;
          err_d       = 1'b0;
        end else if (w_aligned) begin
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, counter and flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      row_count_q <= '0;
      err_q       <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_count_q <= row_count_d;
      err_q       <= err_d;
      irq_q       <= irq_d;
    end
  end

  // --------------------------------------------------------------------------
  // Row buffer: deliberately not reset so results survive a reset
  // --------------------------------------------------------------------------
  logic [ROW_BITS-1:0] buf_q [WIDTH_HEIGHT];

  // Capture an aligned row at the current row index
  always_ff @(posedge clk) begin
    if (w_wr_en) buf_q[row_count_q] <= w_drow;
  end

  // --------------------------------------------------------------------------
  // Avalon read path: one-cycle latency, holds when no read is issued
  // --------------------------------------------------------------------------
  logic [7:0]            w_a;
  logic [ROW_AW-1:0]     w_rd_row;
  logic [WORD_AW-1:0]    w_rd_word;
  logic [ROW_BITS-1:0]   w_rd_bits;
  logic [DATA_WIDTH-1:0] readdata_q, readdata_d;

  assign w_a       = slave_address[7:0];
  assign w_rd_row  = w_a[WORD_AW +: ROW_AW];
  assign w_rd_word = w_a[WORD_AW-1:0];
  assign w_rd_bits = buf_q[w_rd_row];

  // Decode the output region; buffer reads see the pre-write contents
  always_comb begin
    readdata_d = readdata_q;
    if (slave_read) begin
      readdata_d = '0;
      if (slave_address[9:8] == OUTPUT_OFFSET) begin
        if (!w_a[7]) begin
          readdata_d = w_rd_bits[w_rd_word*DATA_WIDTH +: DATA_WIDTH];
        end else if (w_a == STATUS_ADDR) begin
          readdata_d[STAT_ERR_BIT]  = err_q;
          readdata_d[STAT_DONE_BIT] = (state_q == DONE);
          readdata_d[STAT_BUSY_BIT] = (state_q == COLLECT);
        end
      end
    end
  end

  // Read data register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) readdata_q <= '0;
    else       readdata_q <= readdata_d;
  end

  assign slave_readdata = readdata_q;
  assign busy           = (state_q == COLLECT);
  assign done           = (state_q == DONE);
  assign err            = err_q;
  assign irq            = irq_q;

endmodule : tpu_output_collector
`default_nettype wire

// File: tb/tb_tpu_output_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_tpu_output_collector
// Description : Directed self-checking bench for tpu_output_collector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tpu_output_collector;

  localparam int WH = 16;
  localparam int OW = 16;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WH-1:0]    arr_valid;
  logic [WH*OW-1:0] arr_data;
  logic [9:0]       slave_address;
  logic             slave_read;
  logic [DW-1:0]    slave_readdata;
  logic             busy, done, err, irq;

  int n_total = 0;
  int n_pass  = 0;
  int irq_cnt = 0;
  int irq_base;
  logic [31:0] rd;

  tpu_output_collector #(
    .WIDTH_HEIGHT (WH),
    .OUT_WIDTH    (OW),
    .DATA_WIDTH   (DW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .arr_valid      (arr_valid),
    .arr_data       (arr_data),
    .slave_address  (slave_address),
    .slave_read     (slave_read),
    .slave_readdata (slave_readdata),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  // Count irq cycles, sampled mid-cycle
  always @(negedge clk) if (irq === 1'b1) irq_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // All tasks start and end 1 time unit after a rising edge
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_read(input logic [9:0] addr, output logic [31:0] data);
    slave_address = addr;
    slave_read    = 1'b1;
    @(posedge clk); #1;
    slave_read    = 1'b0;
    data          = slave_readdata;
  endtask

  // Drive n skewed rows, value = base + row*16 + col. If er>=0, column ec of
  // row er is presented one cycle early instead of on time.
  task automatic feed(input int n, input logic [15:0] base, input int er, input int ec);
    logic [WH-1:0]    v;
    logic [WH*OW-1:0] d;
    int r;
    for (int t = 0; t < n + WH - 1; t++) begin
      v = '0;
      d = '0;
      for (int c = 0; c < WH; c++) begin
        r = t - c;
        if (r >= 0 && r < n && !(r == er && c == ec)) begin
          v[c] = 1'b1;
          d[c*OW +: OW] = base + 16'(r*16 + c);
        end
        if (c == ec && (t + 1 - c) == er) begin
          v[c] = 1'b1;
          d[c*OW +: OW] = base + 16'(er*16 + c);
        end
      end
      arr_valid = v;
      arr_data  = d;
      @(posedge clk); #1;
    end
    arr_valid = '0;
    arr_data  = '0;
  endtask

  function automatic logic [31:0] w0(input logic [15:0] base);
    return {base + 16'd1, base};
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; arr_valid = '0; arr_data = '0;
    slave_address = '0; slave_read = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    chk("rst_rdata", slave_readdata, 32'h0);
    chk("rst_flags", {28'h0, irq, err, done, busy}, 32'h0);
    do_read(10'h380, rd);
    chk("rst_status", rd, 32'h0);

    // Full clean matrix
    irq_base = irq_cnt;
    pulse_start();
    chk("t2_busy", {31'h0, busy}, 32'h1);
    feed(16, 16'h0000, -1, -1);
    chk("t2_done", {30'h0, done, busy}, 32'h2);
    chk("t2_irq_hi", {31'h0, irq}, 32'h1);
    do_read(10'h31A, rd);
    chk("t2_r3w2", rd, 32'h0035_0034);
    chk("t2_irq_lo", {31'h0, irq}, 32'h0);
    chk("t2_irq_once", 32'(irq_cnt - irq_base), 32'd1);
    do_read(10'h37F, rd);
    chk("t2_r15w7", rd, 32'h00FF_00FE);
    do_read(10'h380, rd);
    chk("t2_status", rd, 32'h2);

    // Skewed column arrives early -> error, no write
    pulse_start();
    feed(1, 16'h0100, 0, 5);
    do_read(10'h380, rd);
    chk("t3_err_status", rd, 32'h5);
    pulse_start();
    chk("t3_err_clr", {31'h0, err}, 32'h0);
    feed(16, 16'h0100, -1, -1);
    do_read(10'h380, rd);
    chk("t3_done_status", rd, 32'h2);
    do_read(10'h300, rd);
    chk("t3_r0w0", rd, w0(16'h0100));

    // Restart part-way through
    irq_base = irq_cnt;
    pulse_start();
    feed(7, 16'h0200, -1, -1);
    do_read(10'h380, rd);
    chk("t4_partial", rd, 32'h1);
    pulse_start();
    feed(16, 16'h0300, -1, -1);
    chk("t4_done", {31'h0, done}, 32'h1);
    do_read(10'h300, rd);
    chk("t4_r0w0", rd, w0(16'h0300));
    chk("t4_irq_once", 32'(irq_cnt - irq_base), 32'd1);

    // Extra row while DONE -> error, buffer untouched
    feed(1, 16'h0400, -1, -1);
    do_read(10'h380, rd);
    chk("t6_status", rd, 32'h6);
    do_read(10'h300, rd);
    chk("t6_r0w0", rd, w0(16'h0300));
    do_read(10'h390, rd);
    chk("t6_rd390", rd, 32'h0);
    do_read(10'h100, rd);
    chk("t6_rd100", rd, 32'h0);

    // Asynchronous reset in the middle of collection
    pulse_start();
    feed(10, 16'h0500, -1, -1);
    chk("t5_busy_pre", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    #1;
    chk("t5_async_flags", {28'h0, irq, err, done, busy}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    feed(16, 16'h0600, -1, -1);
    do_read(10'h380, rd);
    chk("t5_idle_status", rd, 32'h0);
    do_read(10'h300, rd);
    chk("t5_r0w0", rd, w0(16'h0500));
    do_read(10'h34A, rd);
    chk("t5_r9w2", rd, {16'h0500 + 16'h0095, 16'h0500 + 16'h0094});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_tpu_output_collector
`default_nettype wire
